// File: rtl/sched_pkg.sv
// Shared definitions for the SMT issue scheduler and its per-thread producers.
package sched_pkg;

  // Instruction formats
  localparam int IN_INSN_WIDTH    = 100;
  localparam int OUT_INSN_WIDTH   = 96;
  localparam int ADDR_WIDTH       = 32;
  localparam int IS_BRANCH_OFFSET = 9;
  localparam int IS_MEM_OFFSET    = 1 + 8 + 1 + ADDR_WIDTH + 1;
  localparam int CONT_BIT         = IN_INSN_WIDTH - 1;

  // Per-thread instruction queue geometry
  localparam int IQ_DEPTH     = 16;
  localparam int IQ_PTR_WIDTH = 4;
  localparam int IQ_SLOTS     = 4;

  // Scheduler advance response: how many head entries were consumed, minus one
  typedef enum logic [1:0] {
    ADV_1 = 2'd0,
    ADV_2 = 2'd1,
    ADV_3 = 2'd2,
    ADV_4 = 2'd3
  } advance_e;

  // Number of entries a given advance code consumes (1..4)
  function automatic logic [2:0] advance_entries(input logic [1:0] adv);
    return {1'b0, adv} + 3'd1;
  endfunction

endpackage

// File: rtl/iq_head_view.sv
// Combinational head window of the instruction queue: the oldest four
// entries in age order, wrapping at the end of storage, invalid slots zeroed.
module iq_head_view
  import sched_pkg::*;
#(
  parameter int INSN_WIDTH = sched_pkg::IN_INSN_WIDTH,
  parameter int DEPTH      = sched_pkg::IQ_DEPTH,
  parameter int PTR_WIDTH  = sched_pkg::IQ_PTR_WIDTH
) (
  input  logic [INSN_WIDTH-1:0]   mem [DEPTH],
  input  logic [PTR_WIDTH-1:0]    head,
  input  logic [PTR_WIDTH:0]      count,
  output logic [4*INSN_WIDTH-1:0] insns,
  output logic [3:0]              valid
);

  // Select slot k from head+k (pointer arithmetic wraps naturally) when occupied
  always_comb begin
    // NOTE: every output gets a default before the conditional assignments,
    // otherwise the unassigned paths would infer latches.
    insns = '0;
    valid = '0;
    for (int k = 0; k < 4; k++) begin
      if (count > (PTR_WIDTH + 1)'(k)) begin
        valid[k]                         = 1'b1;
        insns[k*INSN_WIDTH +: INSN_WIDTH] = mem[head + PTR_WIDTH'(k)];
      end
    end
  end

endmodule

// File: rtl/thread_insn_queue.sv
// Per-thread circular instruction queue feeding the SMT issue scheduler.
// Accepts up to four decoded instructions per cycle, presents the oldest
// four, and retires entries according to the scheduler's stall/advance reply.
module thread_insn_queue
  import sched_pkg::*;
#(
  parameter int IN_INSN_WIDTH = sched_pkg::IN_INSN_WIDTH,
  parameter int DEPTH         = sched_pkg::IQ_DEPTH,
  parameter int PTR_WIDTH     = sched_pkg::IQ_PTR_WIDTH
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset,
  input  logic                       i_Flush,
  input  logic [4*IN_INSN_WIDTH-1:0] i_Push_Insns,
  input  logic [2:0]                 i_Push_Count,
  output logic                       o_Push_Ready,
  output logic [4*IN_INSN_WIDTH-1:0] o_Insns,
  output logic [3:0]                 o_Valid,
  input  logic                       i_Stall,
  input  logic [1:0]                 i_Advance,
  output logic [PTR_WIDTH:0]         o_Count
);

  localparam int CW = PTR_WIDTH + 1;

  logic [IN_INSN_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]     head;
  logic [PTR_WIDTH-1:0]     tail;
  logic [CW-1:0]            count;
  logic [2:0]               adv_entries;
  logic [2:0]               pop;
  logic [2:0]               push;
  logic                     push_ready;

  // Accept/retire amounts; ready is conservative and ignores same-cycle pops
  always_comb begin
    push_ready  = count <= CW'(DEPTH - 4);
    adv_entries = advance_entries(i_Advance);
    pop         = 3'd0;
    if (!i_Stall) begin
      // Cap at occupancy so an over-request never underflows the queue
      pop = (CW'(adv_entries) > count) ? count[2:0] : adv_entries;
    end
    push = push_ready ? i_Push_Count : 3'd0;
  end

  // Pointer and occupancy state; flush outranks any same-cycle push or pop
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (i_Flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_WIDTH'(pop);
      tail  <= tail + PTR_WIDTH'(push);
      count <= count - CW'(pop) + CW'(push);
    end
  end

  // Entry storage written at the tail; contents are only observed when valid
  always_ff @(posedge i_Clk) begin
    // NOTE: storage has no reset; occupancy masking guarantees stale or
    // unwritten entries are never presented, and a reset-free array maps
    // to plain flops or RAM without a reset tree.
    if (!i_Flush) begin
      for (int j = 0; j < 4; j++) begin
        if (3'(j) < push) begin
          mem[tail + PTR_WIDTH'(j)] <= i_Push_Insns[j*IN_INSN_WIDTH +: IN_INSN_WIDTH];
        end
      end
    end
  end

  iq_head_view #(
    .INSN_WIDTH (IN_INSN_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_head_view (
    .mem   (mem),
    .head  (head),
    .count (count),
    .insns (o_Insns),
    .valid (o_Valid)
  );

  assign o_Push_Ready = push_ready;
  assign o_Count      = count;

endmodule

// File: tb/tb_thread_insn_queue.sv
// Self-checking bench for thread_insn_queue: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_thread_insn_queue;

  localparam int W = 100;
  localparam int D = 16;

  typedef logic [W-1:0] insn_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic [4*W-1:0] push_insns;
  logic [2:0]     push_count;
  logic           push_ready;
  logic [4*W-1:0] insns;
  logic [3:0]     valid;
  logic           stall;
  logic [1:0]     advance;
  logic [4:0]     count;

  // Reference model: an ordered queue of held entries plus the head position
  insn_t model_q[$];
  int    model_head;
  insn_t last_pushed [4];

  int checks   = 0;
  int failures = 0;

  logic       prev_ready;
  logic [4:0] prev_count;

  always #5 clk = ~clk;

  thread_insn_queue dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Flush      (flush),
    .i_Push_Insns (push_insns),
    .i_Push_Count (push_count),
    .o_Push_Ready (push_ready),
    .o_Insns      (insns),
    .o_Valid      (valid),
    .i_Stall      (stall),
    .i_Advance    (advance),
    .o_Count      (count)
  );

  function automatic insn_t rand_insn();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[k] = (model_q.size() > k);
    return v;
  endfunction

  function automatic logic [4*W-1:0] exp_insns();
    logic [4*W-1:0] r;
    r = '0;
    for (int k = 0; k < 4; k++)
      if (k < model_q.size()) r[k*W +: W] = model_q[k];
    return r;
  endfunction

  // One clock cycle of stimulus with fresh payloads; updates the model
  task automatic step(input logic f, input int pc, input logic st, input int adv);
    bit ready_m;
    int pop;
    ready_m = (D - model_q.size()) >= 4;
    checks++;
    if (push_ready !== ready_m) begin
      failures++;
      $display("FAIL push_ready got=%b exp=%b size=%0d", push_ready, ready_m, model_q.size());
    end
    for (int j = 0; j < 4; j++) begin
      last_pushed[j]      = rand_insn();
      push_insns[j*W +: W] = last_pushed[j];
    end
    flush      = f;
    push_count = 3'(pc);
    stall      = st;
    advance    = 2'(adv);
    @(posedge clk);
    #1;
    if (f) begin
      model_q.delete();
      model_head = 0;
    end else begin
      pop = st ? 0 : ((adv + 1 < model_q.size()) ? adv + 1 : model_q.size());
      for (int i = 0; i < pop; i++) void'(model_q.pop_front());
      model_head = (model_head + pop) % D;
      if (ready_m)
        for (int j = 0; j < pc; j++) model_q.push_back(last_pushed[j]);
    end
    flush      = 1'b0;
    push_count = 3'd0;
    stall      = 1'b1;
    advance    = 2'd0;
  endtask

  // Continuous properties: bounded occupancy, thermometer valid, legal push
  // count, and no growth in a cycle that followed a not-ready cycle.
  always @(posedge clk) begin
    prev_ready <= push_ready;
    prev_count <= count;
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (count > 5'(D)) begin
        failures++;
        $display("FAIL count_bound got=%0d max=%0d", count, D);
      end
      checks++;
      if (!(valid inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111})) begin
        failures++;
        $display("FAIL valid_thermo got=%b", valid);
      end
      checks++;
      if (push_count > 3'd4) begin
        failures++;
        $display("FAIL push_count_legal got=%0d max=4", push_count);
      end
      checks++;
      if (!prev_ready && count > prev_count) begin
        failures++;
        $display("FAIL push_when_not_ready got=%0d prev=%0d", count, prev_count);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (count !== 5'd0 || valid !== 4'b0000 || insns !== '0 || push_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state got count=%0d valid=%b ready=%b exp count=0 valid=0000 ready=1",
               count, valid, push_ready);
    end
    rst = 1'b0;
    model_q.delete();
    model_head = 0;
  endtask

  task automatic test_push_stall();
    insn_t a [4];
    step(1'b0, 4, 1'b1, 0);
    a = last_pushed;
    checks++;
    if (valid !== 4'b1111 || count !== 5'd4 || insns[0 +: W] !== a[0] || insns[3*W +: W] !== a[3]) begin
      failures++;
      $display("FAIL push4_view got valid=%b count=%0d slot0=%h exp valid=1111 count=4 slot0=%h",
               valid, count, insns[0 +: W], a[0]);
    end
    step(1'b0, 0, 1'b1, 3);
    step(1'b0, 0, 1'b1, 3);
    checks++;
    if (count !== 5'd4 || insns[0 +: W] !== a[0] || insns[W +: W] !== a[1]) begin
      failures++;
      $display("FAIL stall_hold got count=%0d slot0=%h exp count=4 slot0=%h", count, insns[0 +: W], a[0]);
    end
  endtask

  task automatic test_advance();
    insn_t a2;
    insn_t a3;
    a2 = model_q[2];
    a3 = model_q[3];
    step(1'b0, 0, 1'b0, 1);
    checks++;
    if (count !== 5'd2 || valid !== 4'b0011 || insns[0 +: W] !== a2 || insns[W +: W] !== a3) begin
      failures++;
      $display("FAIL advance2 got count=%0d valid=%b slot0=%h exp count=2 valid=0011 slot0=%h",
               count, valid, insns[0 +: W], a2);
    end
  endtask

  task automatic test_pop_cap();
    step(1'b0, 0, 1'b0, 3);
    checks++;
    if (count !== 5'd0 || valid !== 4'b0000 || insns !== '0) begin
      failures++;
      $display("FAIL pop_cap got count=%0d valid=%b exp count=0 valid=0000 insns=0", count, valid);
    end
  endtask

  task automatic test_full_ready();
    insn_t first;
    step(1'b0, 4, 1'b1, 0);
    first = last_pushed[0];
    step(1'b0, 4, 1'b1, 0);
    step(1'b0, 4, 1'b1, 0);
    step(1'b0, 1, 1'b1, 0);
    checks++;
    if (count !== 5'd13 || push_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill13 got count=%0d ready=%b exp count=13 ready=0", count, push_ready);
    end
    step(1'b0, 4, 1'b1, 0);
    checks++;
    if (count !== 5'd13) begin
      failures++;
      $display("FAIL push_ignored got count=%0d exp=13", count);
    end
    step(1'b0, 0, 1'b0, 0);
    checks++;
    if (count !== 5'd12 || push_ready !== 1'b1 || insns[0 +: W] === first) begin
      failures++;
      $display("FAIL pop1_ready got count=%0d ready=%b exp count=12 ready=1", count, push_ready);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 3);
    checks++;
    if (count !== 5'd0) begin
      failures++;
      $display("FAIL drain got count=%0d exp=0", count);
    end
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    while (model_head != 14 && guard < 40) begin
      step(1'b0, 1, 1'b1, 0);
      step(1'b0, 0, 1'b0, 0);
      guard++;
    end
    checks++;
    if (model_head != 14 || count !== 5'd0) begin
      failures++;
      $display("FAIL wrap_setup got head=%0d count=%0d exp head=14 count=0", model_head, count);
    end
    step(1'b0, 4, 1'b1, 0);
    checks++;
    if (valid !== 4'b1111 || insns !== {last_pushed[3], last_pushed[2], last_pushed[1], last_pushed[0]}) begin
      failures++;
      $display("FAIL wrap_view got valid=%b slot2=%h exp valid=1111 slot2=%h",
               valid, insns[2*W +: W], last_pushed[2]);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 4, 1'b1, 0);
    checks++;
    if (count !== 5'd16 || push_ready !== 1'b0 || insns !== exp_insns()) begin
      failures++;
      $display("FAIL exact_full got count=%0d ready=%b exp count=16 ready=0", count, push_ready);
    end
  endtask

  task automatic test_flush_reset();
    step(1'b0, 0, 1'b0, 3);
    step(1'b0, 0, 1'b0, 2);
    checks++;
    if (count !== 5'd9) begin
      failures++;
      $display("FAIL flush_setup got count=%0d exp=9", count);
    end
    step(1'b1, 3, 1'b0, 1);
    checks++;
    if (count !== 5'd0 || valid !== 4'b0000 || insns !== '0) begin
      failures++;
      $display("FAIL flush got count=%0d valid=%b exp count=0 valid=0000", count, valid);
    end
    step(1'b0, 4, 1'b1, 0);
    step(1'b0, 3, 1'b1, 0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 5'd0 || valid !== 4'b0000 || insns !== '0 || push_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got count=%0d valid=%b ready=%b exp count=0 valid=0000 ready=1",
               count, valid, push_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    model_head = 0;
    step(1'b0, 2, 1'b1, 0);
    checks++;
    if (count !== 5'd2 || insns[0 +: W] !== last_pushed[0]) begin
      failures++;
      $display("FAIL post_reset_push got count=%0d slot0=%h exp count=2 slot0=%h",
               count, insns[0 +: W], last_pushed[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      step(($urandom_range(0, 24) == 0), $urandom_range(0, 4),
           ($urandom_range(0, 2) == 0), $urandom_range(0, 3));
      checks++;
      if (count !== 5'(model_q.size())) begin
        failures++;
        $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", n, count, model_q.size());
      end
      checks++;
      if (valid !== exp_valid()) begin
        failures++;
        $display("FAIL rand_valid cyc=%0d got=%b exp=%b", n, valid, exp_valid());
      end
      checks++;
      if (insns !== exp_insns()) begin
        failures++;
        $display("FAIL rand_insns cyc=%0d got=%h exp=%h", n, insns, exp_insns());
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    push_insns = '0;
    push_count = 3'd0;
    stall      = 1'b1;
    advance    = 2'd0;
    model_head = 0;
    test_reset();
    test_push_stall();
    test_advance();
    test_pop_cap();
    test_full_ready();
    test_wrap();
    test_flush_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/thread_insn_queue.md
Name: thread_insn_queue

Overview:
- Per-thread instruction queue that feeds the SMT issue scheduler. It is the producer end of the scheduler's per-thread interface.
- Buffers decoded instructions from fetch/decode in a circular FIFO.
- Presents the oldest 4 entries with per-slot valid bits.
- Retires entries according to the scheduler's stall/advance response for that thread.
- One instance per hardware thread (4 total).

Parameters:
- IN_INSN_WIDTH, 100, width of one queued instruction; bit IN_INSN_WIDTH-1 is the bundle-continuation bit.
- DEPTH, 16, number of entries; power of two, at least 8.
- PTR_WIDTH, 4, log2(DEPTH).

Ports:
- i_Clk  input  1  clock.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Flush  input  1  discard all queued entries (mispredict/thread squash).
- i_Push_Insns  input  4*IN_INSN_WIDTH  up to 4 new instructions; slot 0 is oldest.
- i_Push_Count  input  3  number of slots of i_Push_Insns to enqueue (0..4).
- o_Push_Ready  output  1  at least 4 free entries this cycle.
- o_Insns  output  4*IN_INSN_WIDTH  head entries; slot 0 is the oldest.
- o_Valid  output  4  o_Valid[k] = occupancy > k.
- i_Stall  input  1  scheduler took nothing from this thread this cycle.
- i_Advance  input  2  when not stalled, the scheduler consumed i_Advance+1 head entries.
- o_Count  output  PTR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, i_Reset=1):
  - head=0, tail=0, count=0.
  - o_Valid=0, o_Insns=0, o_Push_Ready=1, o_Count=0.
  - Storage contents are don't-care.
- Storage: DEPTH x IN_INSN_WIDTH register array, indexed by head/tail pointers. Pointers wrap modulo DEPTH.
- Head view (combinational from registered state):
  - o_Insns slot k = mem[(head+k) mod DEPTH] when count>k; otherwise slot k is driven 0.
  - o_Valid is thermometer-coded: only 0000, 0001, 0011, 0111, 1111 are legal.
- Pop amount:
  - pop = 0 if i_Stall=1.
  - Otherwise pop = min(i_Advance+1, count).
  - pop is capped, so requesting more entries than are held never underflows.
- Push amount:
  - push = i_Push_Count when o_Push_Ready=1; otherwise 0 (the request is ignored; the producer must hold it).
  - i_Push_Count>4 is illegal; the bench asserts on it.
- o_Push_Ready = (DEPTH - count) >= 4, evaluated on registered count. It is conservative: it does not credit same-cycle pops.
- Per-cycle update (clock edge, priority order):
  1. i_Flush=1: head<=0, tail<=0, count<=0. Same-cycle pop and push are discarded.
  2. Otherwise: head<=head+pop, tail<=tail+push, count<=count-pop+push.
  3. Push slot j (j<push) writes mem[(tail+j) mod DEPTH].
- Simultaneous push and pop: both apply in the same cycle.
  - Pushed entries become visible on o_Insns/o_Valid the next cycle, never combinationally.
  - A push into an empty queue appears at slot 0 one cycle later.
- Wrap-around: pushes and the head view span the DEPTH-1 to 0 boundary transparently.
- Full: count can reach DEPTH only through exact fills. count never exceeds DEPTH, given the ready rule.
- Reset mid-operation: all queued entries are lost immediately; outputs go to reset values asynchronously.
- Assertions (bench):
  - count never exceeds DEPTH.
  - No push while o_Push_Ready=0 with nonzero count.
  - o_Valid is always thermometer-coded.

Decomposition:
- Shared package (sched_pkg):
  - IN_INSN_WIDTH, OUT_INSN_WIDTH, ADDR_WIDTH.
  - IS_BRANCH_OFFSET=9, IS_MEM_OFFSET=1+8+1+ADDR_WIDTH+1, CONT_BIT=IN_INSN_WIDTH-1.
  - Advance encoding constants ADV_1..ADV_4 = 0..3.
- Sub-module: one natural one, iq_head_view. It is combinational: it selects the 4 head entries with wrap-around and zero-masks invalid slots.
- Pointer/count logic stays in the top module.

Test Plan:
- Reset, push 4 insns A0..A3 with i_Stall=1 -> next cycle o_Valid=1111, slot0=A0, o_Count=4; contents held while stall remains 1.
- count=4, i_Stall=0, i_Advance=1 -> next cycle o_Count=2, slot0=A2, slot1=A3, o_Valid=0011.
- count=2, i_Stall=0, i_Advance=3 -> pop capped at 2; next cycle o_Count=0, o_Valid=0000, o_Insns=0.
- Fill to 13 entries -> o_Push_Ready=0; push of 4 ignored and o_Count stays 13; pop 1 -> o_Count=12, o_Push_Ready=1.
- Run head/tail across the wrap (head=14, count=4) -> slot order mem[14], mem[15], mem[0], mem[1].
- count=9 with simultaneous push 3, pop 2, i_Flush=1 -> next cycle o_Count=0, o_Valid=0000; assert i_Reset mid-stream -> outputs zero immediately.
